// File: rtl/kianv_mem_access.sv
// Bus-side memory access sequencer: one captured core request per bus
// transaction, with a watchdog that turns a hung bus cycle into a fault.
module kianv_mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        core_valid,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_wstrb,
  output logic        core_ready,
  output logic [31:0] core_rdata,
  output logic        core_fault,
  output logic        core_fault_store,
  output logic [31:0] core_badaddr,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW =
    (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TLIM =
    (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TLIM);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          fault_q, fault_d;
  logic          fstore_q, fstore_d;
  logic [31:0]   badaddr_q, badaddr_d;
  logic          valid_q, valid_d;
  logic          ready_q, ready_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    fault_d   = fault_q;
    fstore_d  = fstore_q;
    badaddr_d = badaddr_q;
    unique case (state_q)
      IDLE: begin
        if (core_valid) begin
          addr_d  = core_addr;
          wdata_d = core_wdata;
          wstrb_d = core_wstrb;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ready) begin
          if (wstrb_q == 4'b0000) rdata_d = mem_rdata;
          fault_d = 1'b0;
          state_d = RESP;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          // ready in the same cycle as expiry takes priority above
          if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
            fault_d   = 1'b1;
            badaddr_d = addr_q;
            fstore_d  = |wstrb_q;
            state_d   = RESP;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == REQ);
    ready_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      fault_q   <= 1'b0;
      fstore_q  <= 1'b0;
      badaddr_q <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      fault_q   <= fault_d;
      fstore_q  <= fstore_d;
      badaddr_q <= badaddr_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
    end
  end

  assign mem_valid        = valid_q;
  assign mem_addr         = {addr_q[31:2], 2'b00};
  assign mem_wdata        = wdata_q;
  assign mem_wstrb        = wstrb_q;
  assign core_ready       = ready_q;
  assign core_rdata       = rdata_q;
  assign core_fault       = fault_q;
  assign core_fault_store = fstore_q;
  assign core_badaddr     = badaddr_q;

endmodule
